// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter (ALU > LSU > MDU) with a pending scoreboard for long-latency results.
// Optional write-back forwarding to decode is enabled by defining WB_FWD_EN.
module regfile_wb_arbiter #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_addr,
  input  logic [DW-1:0] alu_data,
  input  logic          lsu_valid,
  input  logic [AW-1:0] lsu_addr,
  input  logic [DW-1:0] lsu_data,
  output logic          lsu_ready,
  input  logic          mdu_valid,
  input  logic [AW-1:0] mdu_addr,
  input  logic [DW-1:0] mdu_data,
  output logic          mdu_ready,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_addr,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  output logic          stall,
`ifdef WB_FWD_EN
  output logic [DW-1:0] rs_fwd,
  output logic [DW-1:0] rt_fwd,
  output logic          rs_hit,
  output logic          rt_hit,
`endif
  output logic          wb_we,
  output logic [AW-1:0] wb_addr,
  output logic [DW-1:0] wb_data
);

  localparam int NREG = 32'd1 << AW;

  logic [NREG-1:0] pending_q, pending_d;
  logic            wb_we_q, wb_we_d;
  logic [AW-1:0]   wb_addr_q, wb_addr_d;
  logic [DW-1:0]   wb_data_q, wb_data_d;

  logic            live;
  logic            alu_acc, lsu_acc, mdu_acc;
  logic            win_valid;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;
  logic [NREG-1:0] clr_mask, set_mask;
  logic            rs_pend, rt_pend;
  logic            rs_hit_int, rt_hit_int;

  // Reset holds the readies low so no handshake completes in a reset cycle.
  assign live = ena & ~rst;

  always_comb begin
    alu_acc = live & alu_valid;
    lsu_acc = live & lsu_valid & ~alu_valid;
    mdu_acc = live & mdu_valid & ~alu_valid & ~lsu_valid;
  end

  assign lsu_ready = lsu_acc;
  assign mdu_ready = mdu_acc;

  always_comb begin
    win_valid = 1'b0;
    win_addr  = {AW{1'b0}};
    win_data  = {DW{1'b0}};
    if (alu_acc) begin
      win_valid = 1'b1;
      win_addr  = alu_addr;
      win_data  = alu_data;
    end else if (lsu_acc) begin
      win_valid = 1'b1;
      win_addr  = lsu_addr;
      win_data  = lsu_data;
    end else if (mdu_acc) begin
      win_valid = 1'b1;
      win_addr  = mdu_addr;
      win_data  = mdu_data;
    end else begin
      win_valid = 1'b0;
    end
  end

  always_comb begin
    wb_we_d   = win_valid & (win_addr != {AW{1'b0}});
    wb_addr_d = wb_we_d ? win_addr : wb_addr_q;
    wb_data_d = wb_we_d ? win_data : wb_data_q;
  end

  // Set is applied after clear so a same-cycle issue keeps the register pending.
  always_comb begin
    clr_mask = {NREG{1'b0}};
    set_mask = {NREG{1'b0}};
    if (lsu_acc | mdu_acc) begin
      clr_mask[win_addr] = 1'b1;
    end else begin
      clr_mask = {NREG{1'b0}};
    end
    if (live & issue_valid) begin
      set_mask[issue_addr] = 1'b1;
    end else begin
      set_mask = {NREG{1'b0}};
    end
    pending_d    = (pending_q & ~clr_mask) | set_mask;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_we_q   <= 1'b0;
      wb_addr_q <= {AW{1'b0}};
      wb_data_q <= {DW{1'b0}};
      pending_q <= {NREG{1'b0}};
    end else begin
      wb_we_q   <= wb_we_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      pending_q <= pending_d;
    end
  end

  assign wb_we   = wb_we_q;
  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;

`ifdef WB_FWD_EN
  // The write in flight this cycle is not yet in the register file, so decode takes it from here.
  always_comb begin
    rs_hit_int = wb_we_q & (wb_addr_q == rs_addr) & (rs_addr != {AW{1'b0}});
    rt_hit_int = wb_we_q & (wb_addr_q == rt_addr) & (rt_addr != {AW{1'b0}});
    rs_fwd     = rs_hit_int ? wb_data_q : {DW{1'b0}};
    rt_fwd     = rt_hit_int ? wb_data_q : {DW{1'b0}};
  end
  assign rs_hit = rs_hit_int;
  assign rt_hit = rt_hit_int;
`else
  assign rs_hit_int = 1'b0;
  assign rt_hit_int = 1'b0;
`endif

  always_comb begin
    rs_pend = pending_q[rs_addr] & (rs_addr != {AW{1'b0}});
    rt_pend = pending_q[rt_addr] & (rt_addr != {AW{1'b0}});
    stall   = (rs_pend & ~rs_hit_int) | (rt_pend & ~rt_hit_int);
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: expected writes are queued as stimulus is driven
// and popped whenever the DUT asserts wb_we.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst, ena;
  logic        alu_valid, lsu_valid, mdu_valid, issue_valid;
  logic [4:0]  alu_addr, lsu_addr, mdu_addr, issue_addr, rs_addr, rt_addr;
  logic [31:0] alu_data, lsu_data, mdu_data;
  logic        lsu_ready, mdu_ready, stall, wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
`ifdef WB_FWD_EN
  logic [31:0] rs_fwd, rt_fwd;
  logic        rs_hit, rt_hit;
`endif

  int compared   = 0;
  int mismatched = 0;
  logic [36:0] exp_q[$];

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst), .ena(ena),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_addr(lsu_addr), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .stall(stall),
`ifdef WB_FWD_EN
    .rs_fwd(rs_fwd), .rt_fwd(rt_fwd), .rs_hit(rs_hit), .rt_hit(rt_hit),
`endif
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  // Every write the DUT performs must match the oldest expected write.
  always @(negedge clk) begin
    if (wb_we === 1'b1) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL wb_unexpected: got addr=%0d data=%h, required no write", wb_addr, wb_data);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({wb_addr, wb_data} !== e) begin
          mismatched++;
          $display("FAIL wb_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   wb_addr, wb_data, e[36:32], e[31:0]);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; lsu_valid = 1'b0; mdu_valid = 1'b0; issue_valid = 1'b0;
    alu_addr = 5'd0; lsu_addr = 5'd0; mdu_addr = 5'd0; issue_addr = 5'd0;
    alu_data = 32'd0; lsu_data = 32'd0; mdu_data = 32'd0;
    rs_addr = 5'd0; rt_addr = 5'd0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) cyc();
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL %s_drain: got %0d writes outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b1; idle();
    cyc(); cyc();
    rst = 1'b0;
    #1;
    compared++;
    if ({wb_we, wb_addr, wb_data} !== 38'd0) begin
      mismatched++;
      $display("FAIL reset_wb: got we=%b addr=%0d data=%h, required 0/0/0", wb_we, wb_addr, wb_data);
    end
    compared++;
    if ({stall, lsu_ready, mdu_ready} !== 3'b000) begin
      mismatched++;
      $display("FAIL reset_comb: got stall/lsu_rdy/mdu_rdy=%b, required 000", {stall, lsu_ready, mdu_ready});
    end
    cyc();
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h0000_0777;
    exp_q.push_back({5'd7, 32'h0000_0777});
    cyc();
    // wb_we is high now; a new ALU write arriving under reset must be dropped.
    rst = 1'b1; alu_addr = 5'd2; alu_data = 32'h0000_0222;
    cyc();
    rst = 1'b0; idle();
    #1;
    compared++;
    if (wb_we !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_midop: got wb_we=%b, required 0", wb_we);
    end
    drain("reset");
  endtask

  task automatic test_priority();
    cyc();
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h0000_0033;
    lsu_valid = 1'b1; lsu_addr = 5'd4; lsu_data = 32'h0000_0044;
    mdu_valid = 1'b1; mdu_addr = 5'd5; mdu_data = 32'h0000_0055;
    #1;
    compared++;
    if ({lsu_ready, mdu_ready} !== 2'b00) begin
      mismatched++;
      $display("FAIL prio_alu_cycle: got lsu/mdu ready=%b, required 00", {lsu_ready, mdu_ready});
    end
    exp_q.push_back({5'd3, 32'h0000_0033});
    cyc();
    alu_valid = 1'b0;
    #1;
    compared++;
    if ({lsu_ready, mdu_ready} !== 2'b10) begin
      mismatched++;
      $display("FAIL prio_lsu_cycle: got lsu/mdu ready=%b, required 10", {lsu_ready, mdu_ready});
    end
    exp_q.push_back({5'd4, 32'h0000_0044});
    cyc();
    lsu_valid = 1'b0;
    #1;
    compared++;
    if ({lsu_ready, mdu_ready} !== 2'b01) begin
      mismatched++;
      $display("FAIL prio_mdu_cycle: got lsu/mdu ready=%b, required 01", {lsu_ready, mdu_ready});
    end
    exp_q.push_back({5'd5, 32'h0000_0055});
    cyc();
    idle();
    drain("prio");
  endtask

  task automatic test_scoreboard();
    cyc();
    issue_valid = 1'b1; issue_addr = 5'd8; rs_addr = 5'd8;
    #1;
    compared++;
    if (stall !== 1'b0) begin
      mismatched++;
      $display("FAIL sb_issue_same_cycle: got stall=%b, required 0", stall);
    end
    cyc();
    issue_valid = 1'b0; rs_addr = 5'd0; rt_addr = 5'd8;
    #1;
    compared++;
    if (stall !== 1'b1) begin
      mismatched++;
      $display("FAIL sb_issue_visible: got stall=%b, required 1", stall);
    end
    cyc();
    rt_addr = 5'd0; rs_addr = 5'd8;
    lsu_valid = 1'b1; lsu_addr = 5'd8; lsu_data = 32'hDEAD_BEEF;
    #1;
    compared++;
    if ({lsu_ready, stall} !== 2'b11) begin
      mismatched++;
      $display("FAIL sb_lsu_accept: got ready/stall=%b, required 11", {lsu_ready, stall});
    end
    exp_q.push_back({5'd8, 32'hDEAD_BEEF});
    cyc();
    lsu_valid = 1'b0;
    #1;
    compared++;
    if ({wb_we, wb_addr, wb_data, stall} !== {1'b1, 5'd8, 32'hDEAD_BEEF, 1'b0}) begin
      mismatched++;
      $display("FAIL sb_clear: got we=%b addr=%0d data=%h stall=%b, required 1/8/deadbeef/0",
               wb_we, wb_addr, wb_data, stall);
    end
    idle();
    drain("sb");
  endtask

  task automatic test_zero_addr();
    cyc();
    lsu_valid = 1'b1; lsu_addr = 5'd0; lsu_data = 32'h0000_ABCD;
    issue_valid = 1'b1; issue_addr = 5'd0;
    #1;
    compared++;
    if ({lsu_ready, stall} !== 2'b10) begin
      mismatched++;
      $display("FAIL zero_accept: got ready/stall=%b, required 10", {lsu_ready, stall});
    end
    cyc();
    idle();
    #1;
    compared++;
    if ({wb_we, stall} !== 2'b00) begin
      mismatched++;
      $display("FAIL zero_no_write: got we/stall=%b, required 00", {wb_we, stall});
    end
    cyc();
    compared++;
    if (stall !== 1'b0) begin
      mismatched++;
      $display("FAIL zero_no_pending: got stall=%b, required 0", stall);
    end
  endtask

  task automatic test_set_wins();
    cyc();
    issue_valid = 1'b1; issue_addr = 5'd9;
    cyc();
    mdu_valid = 1'b1; mdu_addr = 5'd9; mdu_data = 32'h0000_0099;
    #1;
    compared++;
    if (mdu_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL setwin_ready: got mdu_ready=%b, required 1", mdu_ready);
    end
    exp_q.push_back({5'd9, 32'h0000_0099});
    cyc();
    idle();
    cyc();
    rs_addr = 5'd9;
    #1;
    compared++;
    if (stall !== 1'b1) begin
      mismatched++;
      $display("FAIL setwin_pending: got stall=%b, required 1", stall);
    end
    mdu_valid = 1'b1; mdu_addr = 5'd9; mdu_data = 32'h0000_0999;
    exp_q.push_back({5'd9, 32'h0000_0999});
    cyc();
    mdu_valid = 1'b0;
    cyc();
    #1;
    compared++;
    if (stall !== 1'b0) begin
      mismatched++;
      $display("FAIL setwin_cleared: got stall=%b, required 0", stall);
    end
    idle();
    drain("setwin");
  endtask

  task automatic test_enable();
    cyc();
    issue_valid = 1'b1; issue_addr = 5'd13;
    cyc();
    idle();
    ena = 1'b0;
    lsu_valid = 1'b1; lsu_addr = 5'd6; lsu_data = 32'h0000_0666;
    issue_valid = 1'b1; issue_addr = 5'd11;
    rs_addr = 5'd13;
    #1;
    compared++;
    if ({lsu_ready, mdu_ready, stall} !== 3'b001) begin
      mismatched++;
      $display("FAIL ena_off_comb: got lsu/mdu/stall=%b, required 001", {lsu_ready, mdu_ready, stall});
    end
    cyc();
    issue_valid = 1'b0; rs_addr = 5'd11;
    #1;
    compared++;
    if ({wb_we, stall} !== 2'b00) begin
      mismatched++;
      $display("FAIL ena_off_state: got we/stall=%b, required 00", {wb_we, stall});
    end
    ena = 1'b1;
    exp_q.push_back({5'd6, 32'h0000_0666});
    cyc();
    lsu_valid = 1'b0;
    lsu_valid = 1'b1; lsu_addr = 5'd13; lsu_data = 32'h0000_1313;
    exp_q.push_back({5'd13, 32'h0000_1313});
    cyc();
    idle();
    drain("ena");
  endtask

  task automatic test_forward();
    cyc();
    issue_valid = 1'b1; issue_addr = 5'd12;
    cyc();
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_addr = 5'd12; alu_data = 32'h0000_1234;
    exp_q.push_back({5'd12, 32'h0000_1234});
    cyc();
    idle();
    rt_addr = 5'd12;
    #1;
`ifdef WB_FWD_EN
    compared++;
    if ({rt_hit, rt_fwd, stall, rs_hit} !== {1'b1, 32'h0000_1234, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL fwd_hit: got hit=%b fwd=%h stall=%b rs_hit=%b, required 1/00001234/0/0",
               rt_hit, rt_fwd, stall, rs_hit);
    end
`else
    compared++;
    if (stall !== 1'b1) begin
      mismatched++;
      $display("FAIL fwd_nofwd_stall: got stall=%b, required 1", stall);
    end
`endif
    cyc();
    compared++;
    if (stall !== 1'b1) begin
      mismatched++;
      $display("FAIL fwd_alu_keeps_pending: got stall=%b, required 1", stall);
    end
    lsu_valid = 1'b1; lsu_addr = 5'd12; lsu_data = 32'h0000_5678;
    exp_q.push_back({5'd12, 32'h0000_5678});
    cyc();
    lsu_valid = 1'b0;
    cyc();
    compared++;
    if (stall !== 1'b0) begin
      mismatched++;
      $display("FAIL fwd_cleared: got stall=%b, required 0", stall);
    end
    idle();
    drain("fwd");
  endtask

  task automatic test_back_to_back();
    cyc();
    lsu_valid = 1'b1; lsu_addr = 5'd20; lsu_data = 32'h0000_2020;
    for (int i = 1; i <= 5; i++) begin
      alu_valid = 1'b1;
      alu_addr  = 5'(i);
      alu_data  = 32'h0000_A000 + 32'(i);
      exp_q.push_back({5'(i), 32'h0000_A000 + 32'(i)});
      #1;
      compared++;
      if (lsu_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL b2b_starve[%0d]: got lsu_ready=%b, required 0", i, lsu_ready);
      end
      cyc();
    end
    alu_valid = 1'b0;
    exp_q.push_back({5'd20, 32'h0000_2020});
    cyc();
    idle();
    drain("b2b");
  endtask

  initial begin
    test_reset();
    test_priority();
    test_scoreboard();
    test_zero_addr();
    test_set_wins();
    test_enable();
    test_forward();
    test_back_to_back();
    cyc(); cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
